// File: rtl/note_event_sequencer_pkg.sv
// Shared definitions for the note event sequencer: master state codes,
// default key count and the sequencer FSM state type.
package note_event_sequencer_pkg;

    // Master FSM state encoding as seen on master_state
    localparam int               MS_W               = 5;
    localparam logic [MS_W-1:0]  MS_STARTSCREEN     = 5'd0;
    localparam logic [MS_W-1:0]  MS_RECORD          = 5'd1;
    localparam logic [MS_W-1:0]  MS_PLAYBACK        = 5'd2;
    localparam logic [MS_W-1:0]  MS_RESTARTPLAYBACK = 5'd3;

    // Number of keyboard inputs tracked by default
    localparam int NUMBEROFKEYBOARDINPUTS = 16;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_PB_FETCH,
        S_PB_LATCH,
        S_PB_WAIT,
        S_PB_DONE
    } seq_state_t;

endpackage

// File: rtl/note_event_sequencer_lowest_set_bit.sv
// Priority encoder: reports whether any bit of i_vec is set and the index
// of the lowest set bit.
module note_event_sequencer_lowest_set_bit #(
    parameter int W     = 16,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     i_vec,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set bit is the last one to win
    always_comb begin
        // NOTE: every output gets a value before any branch so no path infers a latch.
        o_valid = |i_vec;
        o_idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/note_event_sequencer.sv
// Record/playback engine. RECORD turns key-state changes into timestamped
// {ts, key_idx, pressed} words written to an external event RAM; PLAYBACK
// reads them back and applies each to pb_keys once time_now reaches its stamp.
module note_event_sequencer
    import note_event_sequencer_pkg::*;
#(
    parameter int NUM_KEYS = NUMBEROFKEYBOARDINPUTS,
    parameter int KEY_W    = $clog2(NUM_KEYS),
    parameter int TS_W     = 20,
    parameter int ADDR_W   = 10,
    parameter int WORD_W   = TS_W + KEY_W + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [MS_W-1:0]     i_master_state,
    input  logic [NUM_KEYS-1:0] i_key_state,
    input  logic [TS_W-1:0]     i_time_now,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [WORD_W-1:0]   o_mem_wdata,
    output logic                o_mem_we,
    input  logic [WORD_W-1:0]   i_mem_rdata,
    output logic [NUM_KEYS-1:0] o_pb_keys,
    output logic                o_pb_done,
    output logic                o_rec_full,
    output logic [ADDR_W:0]     o_event_count
);

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    seq_state_t          r_state, w_state_nxt, w_pb_start;
    logic [NUM_KEYS-1:0] r_prev_keys, w_prev_keys;
    logic [NUM_KEYS-1:0] r_pending, w_pending;
    logic [NUM_KEYS-1:0] r_pb_keys, w_pb_keys;
    logic [ADDR_W:0]     r_rd_ptr, w_rd_ptr, w_rd_ptr_inc;
    logic [ADDR_W:0]     r_event_count, w_event_count;
    logic [TS_W-1:0]     r_ev_ts, w_ev_ts;
    logic [KEY_W-1:0]    r_ev_idx, w_ev_idx;
    logic                r_ev_pressed, w_ev_pressed;
    logic                r_pb_done, w_pb_done;
    logic                r_rec_full, w_rec_full;

    logic [NUM_KEYS-1:0] w_changes;
    logic [NUM_KEYS-1:0] w_lsb_mask;
    logic                w_lsb_valid;
    logic [KEY_W-1:0]    w_lsb_idx;

    // Keys still waiting to be written plus keys that changed this cycle
    assign w_changes    = r_pending | (i_key_state ^ r_prev_keys);
    assign w_lsb_mask   = {{(NUM_KEYS-1){1'b0}}, 1'b1} << w_lsb_idx;
    assign w_rd_ptr_inc = r_rd_ptr + CNT_ONE;
    assign w_pb_start   = (r_event_count == '0) ? S_PB_DONE : S_PB_FETCH;

    note_event_sequencer_lowest_set_bit #(
        .W     (NUM_KEYS),
        .IDX_W (KEY_W)
    ) u_lowest_set_bit (
        .i_vec   (w_changes),
        .o_valid (w_lsb_valid),
        .o_idx   (w_lsb_idx)
    );

    // Next-state, next-datapath and RAM port decode driven by master_state
    always_comb begin
        w_state_nxt   = r_state;
        w_prev_keys   = r_prev_keys;
        w_pending     = r_pending;
        w_pb_keys     = r_pb_keys;
        w_rd_ptr      = r_rd_ptr;
        w_event_count = r_event_count;
        w_ev_ts       = r_ev_ts;
        w_ev_idx      = r_ev_idx;
        w_ev_pressed  = r_ev_pressed;
        w_pb_done     = r_pb_done;
        w_rec_full    = r_rec_full;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;

        if (i_master_state == MS_RECORD) begin
            if (r_state != S_REC) begin
                // New session: forget the old recording, snapshot the keys
                w_state_nxt   = S_REC;
                w_event_count = '0;
                w_rec_full    = 1'b0;
                w_pending     = '0;
                w_prev_keys   = i_key_state;
                w_pb_keys     = '0;
                w_pb_done     = 1'b0;
                w_rd_ptr      = '0;
            end else begin
                // One event per cycle; the chosen key leaves pending even when dropped
                w_prev_keys = i_key_state;
                w_pending   = w_changes & ~w_lsb_mask;
                if (w_lsb_valid) begin
                    if (r_event_count == DEPTH) begin
                        w_rec_full = 1'b1;
                    end else begin
                        o_mem_we      = 1'b1;
                        o_mem_addr    = r_event_count[ADDR_W-1:0];
                        o_mem_wdata   = {i_time_now, w_lsb_idx, i_key_state[w_lsb_idx]};
                        w_event_count = r_event_count + CNT_ONE;
                    end
                end
            end
        end else if (i_master_state == MS_PLAYBACK || i_master_state == MS_RESTARTPLAYBACK) begin
            if (r_state == S_IDLE || r_state == S_REC || i_master_state == MS_RESTARTPLAYBACK) begin
                // (Re)start replay from the first stored event
                w_state_nxt = w_pb_start;
                w_rd_ptr    = '0;
                w_pb_keys   = '0;
                w_pb_done   = (r_event_count == '0);
            end else begin
                unique case (r_state)
                    S_PB_FETCH: begin
                        o_mem_addr  = r_rd_ptr[ADDR_W-1:0];
                        w_state_nxt = S_PB_LATCH;
                    end
                    S_PB_LATCH: begin
                        w_ev_ts      = i_mem_rdata[WORD_W-1 -: TS_W];
                        w_ev_idx     = i_mem_rdata[1 +: KEY_W];
                        w_ev_pressed = i_mem_rdata[0];
                        w_state_nxt  = S_PB_WAIT;
                    end
                    S_PB_WAIT: begin
                        if (i_time_now >= r_ev_ts) begin
                            w_pb_keys[r_ev_idx] = r_ev_pressed;
                            w_rd_ptr            = w_rd_ptr_inc;
                            if (w_rd_ptr_inc == r_event_count) begin
                                w_pb_done   = 1'b1;
                                w_state_nxt = S_PB_DONE;
                            end else begin
                                w_state_nxt = S_PB_FETCH;
                            end
                        end
                    end
                    default: begin
                        w_pb_done = 1'b1;
                    end
                endcase
            end
        end else begin
            // Start screen or unrecognised code: park, keep the recording
            w_state_nxt = S_IDLE;
            w_pb_keys   = '0;
            w_pb_done   = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: key tracking, pointers, latched event, status
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prev_keys   <= '0;
            r_pending     <= '0;
            r_pb_keys     <= '0;
            r_rd_ptr      <= '0;
            r_event_count <= '0;
            r_ev_ts       <= '0;
            r_ev_idx      <= '0;
            r_ev_pressed  <= 1'b0;
            r_pb_done     <= 1'b0;
            r_rec_full    <= 1'b0;
        end else begin
            r_prev_keys   <= w_prev_keys;
            r_pending     <= w_pending;
            r_pb_keys     <= w_pb_keys;
            r_rd_ptr      <= w_rd_ptr;
            r_event_count <= w_event_count;
            r_ev_ts       <= w_ev_ts;
            r_ev_idx      <= w_ev_idx;
            r_ev_pressed  <= w_ev_pressed;
            r_pb_done     <= w_pb_done;
            r_rec_full    <= w_rec_full;
        end
    end

    assign o_pb_keys     = r_pb_keys;
    assign o_pb_done     = r_pb_done;
    assign o_rec_full    = r_rec_full;
    assign o_event_count = r_event_count;

endmodule
